// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op codes and decode helpers for the mul/div unit
//
// MD_* codes are the single definition shared by the decoder and muldiv_unit.

package muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Ops whose operands are two's complement and need magnitude conditioning.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Ops that run the 32-iteration datapath.
    function automatic logic md_is_iter(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - execute-stage <-> mul/div unit bundle
//
// start/op/a/b : issue strobe, MD_* op select, rs and rt operands (master drives)
// busy/done    : iteration in progress, one-cycle result-written pulse (slave drives)
// hi/lo        : architectural HI/LO register outputs (slave drives)

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle multiply/divide unit owning HI/LO
//
// clk   : rising-edge clock
// rst_n : synchronous active-low reset; aborts any operation in flight
// bus   : muldiv_unit_if slave (start/op/a/b in, busy/done/hi/lo out)
//
// IDLE -> RUN (32 iterations, cnt 0..31) -> FINISH (sign fix, write HI/LO) -> IDLE.
// One WIDTH+1 bit adder/subtractor serves both shift-add multiply and restoring divide.

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam int         CW        = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // acc_hi: product high half / partial remainder.
    // acc_lo: multiplier shifting out + product low half / dividend shifting out + quotient.
    // opnd  : multiplicand / divisor magnitude.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;

    // Operand conditioning at issue. |0x80000000| stays 0x80000000 read as unsigned.
    logic             issue_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        issue_signed = md_is_signed(bus.op);
        abs_a        = (issue_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b        = (issue_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // Shared adder. Divide subtracts the divisor from the remainder shifted left
    // by one with the next dividend bit; a clear top bit means no borrow, so the
    // quotient bit is 1 and the difference becomes the new remainder.
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH:0]   add_sum;
    logic             q_bit;
    logic [WIDTH-1:0] div_rem_next;

    always_comb begin
        add_x = {1'b0, acc_hi};
        add_y = {1'b0, opnd};
        if (is_div) begin
            add_x = {acc_hi, acc_lo[WIDTH-1]};
        end else if (!acc_lo[0]) begin
            add_y = '0;
        end
        add_sum      = add_x + (add_y ^ {(WIDTH+1){is_div}}) + {{WIDTH{1'b0}}, is_div};
        q_bit        = ~add_sum[WIDTH];
        div_rem_next = q_bit ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
    end

    // Sign fix-up for FINISH. A zero divisor leaves the all-ones quotient
    // unnegated; the remainder path then reproduces the original dividend.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        if (is_signed && (sign_a ^ sign_b)) begin
            prod_fix = -{acc_hi, acc_lo};
        end
        quot_fix = (is_signed && (sign_a ^ sign_b) && !b_zero) ? -acc_lo : acc_lo;
        rem_fix  = (is_signed && sign_a) ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            b_zero    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == MD_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == MD_MTLO) begin
                            lo_q <= bus.a;
                        end else if (md_is_iter(bus.op)) begin
                            is_div    <= md_is_div(bus.op);
                            is_signed <= issue_signed;
                            sign_a    <= issue_signed & bus.a[WIDTH-1];
                            sign_b    <= issue_signed & bus.b[WIDTH-1];
                            b_zero    <= (bus.b == '0);
                            acc_hi    <= '0;
                            if (md_is_div(bus.op)) begin
                                acc_lo <= abs_a;
                                opnd   <= abs_b;
                            end else begin
                                acc_lo <= abs_b;
                                opnd   <= abs_a;
                            end
                            cnt    <= '0;
                            busy_q <= 1'b1;
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (is_div) begin
                        acc_hi <= div_rem_next;
                        acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
                    end else begin
                        acc_hi <= add_sum[WIDTH:1];
                        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    cnt    <= '0;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit for the mips32 datapath, owning the architectural HI/LO registers. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the execute stage and runs multiply and divide iteratively over 32 cycles. It signals `busy` so the hazard logic can stall MFHI/MFLO and further mul/div issue, and exposes HI/LO continuously for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: issue strobe; sampled only while idle.
- `op` in 3: operation select, using the `MD_*` codes.
- `a` in 32: rs operand; dividend or multiplicand.
- `b` in 32: rt operand; divisor or multiplier.
- `busy` out 1: high while an iteration is in progress.
- `done` out 1: one-cycle pulse when HI/LO receive a mul/div result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- **States:**
  - IDLE: waiting for work.
  - RUN: performing iterations; `cnt` counts 0..31.
  - FINISH: one cycle to fix signs and write HI/LO.
- **Reset** (`rst_n`=0 at an edge): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0.
  - Applies mid-operation: the operation is aborted and no partial result is written.
- **IDLE with `start`=1:**
  - MTHI: `hi`<=`a`, one edge, stay IDLE, no `busy`, no `done`.
  - MTLO: `lo`<=`a`, one edge, stay IDLE, no `busy`, no `done`.
  - MULT/MULTU/DIV/DIVU: latch the operands and op, go to RUN, `busy`<=1.
  - Undefined op code: ignored.
- **`start` outside IDLE:** ignored.
- **Operand conditioning:**
  - Signed ops (MULT, DIV): latch magnitudes |a| and |b|, plus the sign flags.
  - |0x80000000| = 0x80000000 when treated as unsigned.
- **Multiply:** shift-add, one multiplier bit per cycle, 64-bit accumulator.
- **Divide:** restoring division, one quotient bit per cycle, 33-bit partial-remainder subtract.
- **FINISH:**
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write the result: multiply gives `hi`=product[63:32], `lo`=product[31:0]; divide gives `lo`=quotient, `hi`=remainder.
  - Then `done`<=1, `busy`<=0, go to IDLE.
- **Divide by zero** (DIV and DIVU): `lo`=0xFFFFFFFF, `hi`=`a` (original signed value). Takes the full latency.
- **DIV 0x80000000 / 0xFFFFFFFF:** `lo`=0x80000000, `hi`=0. This falls out of the magnitude path; no special case.

## Timing
- **Issue:** start is sampled at edge E0. `busy` is high from E0 through the cycle ending at E33.
- **Iterations:** RUN occupies edges E1..E32. FINISH writes HI/LO at edge E33.
- **Completion:** `done`=1 and the new `hi`/`lo` are visible in the cycle after E33; `busy` is already 0 in that cycle.
- **Back-to-back issue:** a new `start` may be sampled at E34 at the earliest (the done cycle is IDLE).
- **MTHI/MTLO:** the new value is visible in the cycle after the sampling edge.
- **Read path:** `hi`/`lo` are register outputs. There is no bypass from `a` during MTHI/MTLO or from the FINISH computation.
- **`done` pulse:** exactly one cycle and never asserted twice per operation; `done` and `busy` are never high together.

## Structure
- **Shared constants:** `MD_MULT`=0, `MD_MULTU`=1, `MD_DIV`=2, `MD_DIVU`=3, `MD_MTHI`=4, `MD_MTLO`=5.
  - These go in the shared `parameters.v` alongside the `ALU_*` codes, so the decoder and this block share one definition.
- **State encodings:** localparams inside the module.
- **Sub-module:** none required. The datapath is one adder/subtractor shared between the multiply and divide iterations, plus shift registers. Total RTL is about 200 lines.

## Test plan
- **Unsigned multiply:** MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - `busy` is high 33 cycles, then `done`.
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **Signed multiply:** MULT a=0xFFFFFFFD (-3), b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **Signed divide:** DIV a=0xFFFFFFF9 (-7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **Divide corner cases:**
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 0x1234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x1234.
- **HI/LO moves and ignored start:**
  - MTHI 0xAAAA then MTLO 0x5555 → `hi`/`lo` update one cycle later, `done` stays 0.
  - `start`=1 with MULTU held during `busy` → ignored; exactly one `done`.
- **Reset mid-operation:**
  - Issue DIVU 100/7, pull `rst_n` low at cycle 10 → next cycle `busy`=0, `hi`=`lo`=0, no `done`.
  - Re-issue → `lo`=14, `hi`=2.
